// File: rtl/peak_meter.sv
// Multi-channel windowed peak detector: per-channel max magnitude and clip over 2^WIN_LOG2 accepted samples.
// Optional ballistic hold/decay of the published peak enabled by defining PEAK_METER_HOLD_DECAY_EN.
module peak_meter #(
  parameter int BUS_WIDTH = 6,
  parameter int NCH       = 2,
  parameter int WIN_LOG2  = 9,
  parameter int SIGNED    = 0
) (
  input  logic                     dclk,
  input  logic                     rst,
  input  logic [NCH*BUS_WIDTH-1:0] din,
  input  logic                     din_valid,
  input  logic                     clear,
  output logic [NCH*BUS_WIDTH-1:0] maxout,
  output logic                     maxout_valid,
  output logic [NCH-1:0]           clip
);

  localparam logic [BUS_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [BUS_WIDTH-1:0] MOST_NEG = {1'b1, {(BUS_WIDTH-1){1'b0}}};
  localparam logic [BUS_WIDTH-1:0] MAX_POS  = ~MOST_NEG;

  logic [BUS_WIDTH-1:0] smp      [NCH];
  logic [BUS_WIDTH-1:0] mag      [NCH];
  logic [BUS_WIDTH-1:0] peak     [NCH];
  logic [BUS_WIDTH-1:0] run_max  [NCH];
  logic [NCH-1:0]       fullscale;
  logic [NCH-1:0]       run_clip;
  logic [WIN_LOG2-1:0]  count;
  logic                 win_close;

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      smp[k] = din[k*BUS_WIDTH +: BUS_WIDTH];
      if (SIGNED != 0) begin
        // Most negative code has no positive twin; saturate it to MAX_POS.
        if (smp[k] == MOST_NEG)
          mag[k] = MAX_POS;
        else if (smp[k][BUS_WIDTH-1])
          mag[k] = ~smp[k] + 1'b1;
        else
          mag[k] = smp[k];
        fullscale[k] = (smp[k] == MAX_POS) || (smp[k] == MOST_NEG);
      end else begin
        mag[k]       = smp[k];
        fullscale[k] = (smp[k] == ALL_ONES);
      end
      peak[k] = (mag[k] > run_max[k]) ? mag[k] : run_max[k];
    end
  end

  assign win_close = din_valid && !clear && (&count);

`ifdef PEAK_METER_HOLD_DECAY_EN
  logic [BUS_WIDTH-1:0] hold      [NCH];
  logic [BUS_WIDTH-1:0] hold_next [NCH];

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      if (peak[k] >= hold[k])
        hold_next[k] = peak[k];
      else if (hold[k] == '0)
        hold_next[k] = '0;
      else
        hold_next[k] = hold[k] - 1'b1;
    end
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NCH; k++) hold[k] <= '0;
    end else if (win_close) begin
      for (int unsigned k = 0; k < NCH; k++) hold[k] <= hold_next[k];
    end
  end
`endif

  always_ff @(posedge dclk) begin
    if (rst) begin
      maxout       <= '0;
      maxout_valid <= 1'b0;
      clip         <= '0;
      run_clip     <= '0;
      count        <= '0;
      for (int unsigned k = 0; k < NCH; k++) run_max[k] <= '0;
    end else begin
      maxout_valid <= win_close;
      if (clear) begin
        // A sample arriving with clear becomes the first of the new window.
        count    <= din_valid ? WIN_LOG2'(1) : '0;
        run_clip <= din_valid ? fullscale : '0;
        for (int unsigned k = 0; k < NCH; k++)
          run_max[k] <= din_valid ? mag[k] : '0;
      end else if (din_valid) begin
        count <= count + 1'b1;
        if (win_close) begin
          clip     <= run_clip | fullscale;
          run_clip <= '0;
          for (int unsigned k = 0; k < NCH; k++) begin
`ifdef PEAK_METER_HOLD_DECAY_EN
            maxout[k*BUS_WIDTH +: BUS_WIDTH] <= hold_next[k];
`else
            maxout[k*BUS_WIDTH +: BUS_WIDTH] <= peak[k];
`endif
            run_max[k] <= '0;
          end
        end else begin
          run_clip <= run_clip | fullscale;
          for (int unsigned k = 0; k < NCH; k++) run_max[k] <= peak[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_peak_meter.sv
// Directed self-checking bench for peak_meter: an unsigned and a signed instance, both with a 4-sample window.
module tb_peak_meter;

  logic        dclk = 1'b0;
  logic        rst  = 1'b1;
  logic [11:0] din_u = '0, din_s = '0;
  logic        dv_u = 1'b0, dv_s = 1'b0, clr_u = 1'b0, clr_s = 1'b0;
  logic [11:0] mo_u, mo_s;
  logic        mv_u, mv_s;
  logic [1:0]  clip_u, clip_s;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_mo_u, exp_mo_s;

  always #5 dclk = ~dclk;

  peak_meter #(.BUS_WIDTH(6), .NCH(2), .WIN_LOG2(2), .SIGNED(0)) u_uns (
    .dclk(dclk), .rst(rst), .din(din_u), .din_valid(dv_u), .clear(clr_u),
    .maxout(mo_u), .maxout_valid(mv_u), .clip(clip_u));

  peak_meter #(.BUS_WIDTH(6), .NCH(2), .WIN_LOG2(2), .SIGNED(1)) u_sgn (
    .dclk(dclk), .rst(rst), .din(din_s), .din_valid(dv_s), .clear(clr_s),
    .maxout(mo_s), .maxout_valid(mv_s), .clip(clip_s));

`ifdef PEAK_METER_HOLD_DECAY_EN
  logic [5:0] hu0 = '0, hu1 = '0, hs0 = '0, hs1 = '0;

  function automatic logic [5:0] nh(input logic [5:0] h, input logic [5:0] p);
    if (p >= h) return p;
    else if (h == 6'd0) return 6'd0;
    else return h - 6'd1;
  endfunction
`endif

  // Expected published value for a window whose raw peaks are p1:p0.
  task automatic exp_u(input logic [5:0] p0, input logic [5:0] p1);
`ifdef PEAK_METER_HOLD_DECAY_EN
    hu0 = nh(hu0, p0);
    hu1 = nh(hu1, p1);
    exp_mo_u = {hu1, hu0};
`else
    exp_mo_u = {p1, p0};
`endif
  endtask

  task automatic exp_s(input logic [5:0] p0, input logic [5:0] p1);
`ifdef PEAK_METER_HOLD_DECAY_EN
    hs0 = nh(hs0, p0);
    hs1 = nh(hs1, p1);
    exp_mo_s = {hs1, hs0};
`else
    exp_mo_s = {p1, p0};
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc_u(input logic [5:0] a, input logic [5:0] b, input logic v, input logic c);
    @(negedge dclk);
    rst = 1'b0; din_u = {b, a}; dv_u = v; clr_u = c; dv_s = 1'b0; clr_s = 1'b0;
    @(posedge dclk);
    #1;
  endtask

  task automatic cyc_s(input logic [5:0] a, input logic [5:0] b);
    @(negedge dclk);
    rst = 1'b0; din_s = {b, a}; dv_s = 1'b1; clr_s = 1'b0; dv_u = 1'b0; clr_u = 1'b0;
    @(posedge dclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge dclk);
    rst = 1'b1; dv_u = 1'b0; dv_s = 1'b0; clr_u = 1'b0; clr_s = 1'b0;
    @(posedge dclk);
    #1;
`ifdef PEAK_METER_HOLD_DECAY_EN
    hu0 = '0; hu1 = '0; hs0 = '0; hs1 = '0;
`endif
  endtask

  initial begin
    do_reset();
    chk("reset_maxout", mo_u, 12'h000);
    chk("reset_valid", mv_u, 1'b0);
    chk("reset_clip", clip_u, 2'b00);
    chk("reset_sgn_maxout", mo_s, 12'h000);

    // Continuous window: ch0 3,9,4,1 / ch1 0,0,0,63
    cyc_u(6'd3, 6'd0, 1, 0); chk("t1_s1_valid", mv_u, 1'b0);
    cyc_u(6'd9, 6'd0, 1, 0); chk("t1_s2_valid", mv_u, 1'b0);
    cyc_u(6'd4, 6'd0, 1, 0); chk("t1_s3_valid", mv_u, 1'b0);
    cyc_u(6'd1, 6'd63, 1, 0);
    exp_u(6'd9, 6'd63);
    chk("t1_close_valid", mv_u, 1'b1);
    chk("t1_close_maxout", mo_u, exp_mo_u);
    chk("t1_close_clip", clip_u, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cyc_u(6'd0, 6'd0, 1, 0);
      chk("t1_zero_valid", mv_u, 1'b0);
      chk("t1_zero_hold_maxout", mo_u, exp_mo_u);
    end
    cyc_u(6'd0, 6'd0, 1, 0);
    exp_u(6'd0, 6'd0);
    chk("t1_zero_close_valid", mv_u, 1'b1);
    chk("t1_zero_close_maxout", mo_u, exp_mo_u);
    chk("t1_zero_close_clip", clip_u, 2'b00);

    // Gapped valid: three idle cycles between samples
    cyc_u(6'd3, 6'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc_u(6'd0, 6'd0, 0, 0); chk("t2_gap_valid", mv_u, 1'b0); chk("t2_gap_maxout", mo_u, exp_mo_u);
    end
    cyc_u(6'd9, 6'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc_u(6'd0, 6'd0, 0, 0); chk("t2_gap_valid", mv_u, 1'b0); chk("t2_gap_maxout", mo_u, exp_mo_u);
    end
    cyc_u(6'd4, 6'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc_u(6'd0, 6'd0, 0, 0); chk("t2_gap_valid", mv_u, 1'b0); chk("t2_gap_maxout", mo_u, exp_mo_u);
    end
    cyc_u(6'd1, 6'd63, 1, 0);
    exp_u(6'd9, 6'd63);
    chk("t2_close_valid", mv_u, 1'b1);
    chk("t2_close_maxout", mo_u, exp_mo_u);
    chk("t2_close_clip", clip_u, 2'b10);
    cyc_u(6'd0, 6'd0, 0, 0);
    chk("t2_after_valid", mv_u, 1'b0);
    chk("t2_after_maxout", mo_u, exp_mo_u);

    // clear together with a sample restarts the window
    cyc_u(6'd40, 6'd0, 1, 0);
    cyc_u(6'd40, 6'd0, 1, 0);
    cyc_u(6'd10, 6'd0, 1, 1); chk("t3_clear_valid", mv_u, 1'b0);
    cyc_u(6'd1, 6'd0, 1, 0);  chk("t3_s1_valid", mv_u, 1'b0);
    cyc_u(6'd1, 6'd0, 1, 0);  chk("t3_s2_valid", mv_u, 1'b0);
    cyc_u(6'd1, 6'd0, 1, 0);
    exp_u(6'd10, 6'd0);
    chk("t3_close_valid", mv_u, 1'b1);
    chk("t3_close_maxout", mo_u, exp_mo_u);
    chk("t3_close_clip", clip_u, 2'b00);

    // clear alone discards the partial window, leaves published values
    cyc_u(6'd50, 6'd63, 1, 0);
    cyc_u(6'd0, 6'd0, 0, 1);
    chk("t4_clear_valid", mv_u, 1'b0);
    chk("t4_clear_maxout", mo_u, exp_mo_u);
    for (int i = 0; i < 3; i++) begin
      cyc_u(6'd2, 6'd2, 1, 0); chk("t4_fill_valid", mv_u, 1'b0);
    end
    cyc_u(6'd2, 6'd2, 1, 0);
    exp_u(6'd2, 6'd2);
    chk("t4_close_valid", mv_u, 1'b1);
    chk("t4_close_maxout", mo_u, exp_mo_u);
    chk("t4_close_clip", clip_u, 2'b00);

    // rst one cycle before close
    for (int i = 0; i < 3; i++) cyc_u(6'd30, 6'd30, 1, 0);
    do_reset();
    chk("t5_rst_valid", mv_u, 1'b0);
    chk("t5_rst_maxout", mo_u, 12'h000);
    chk("t5_rst_clip", clip_u, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cyc_u(6'd5, 6'd5, 1, 0); chk("t5_fill_valid", mv_u, 1'b0);
    end
    cyc_u(6'd5, 6'd5, 1, 0);
    exp_u(6'd5, 6'd5);
    chk("t5_close_valid", mv_u, 1'b1);
    chk("t5_close_maxout", mo_u, exp_mo_u);

    // Window peaks 20,0,0,25 on ch0 (hold build decays between windows)
    cyc_u(6'd20, 6'd0, 1, 0);
    for (int i = 0; i < 3; i++) cyc_u(6'd0, 6'd0, 1, 0);
    exp_u(6'd20, 6'd0);
    chk("t6_w1_valid", mv_u, 1'b1);
    chk("t6_w1_maxout", mo_u, exp_mo_u);
    for (int i = 0; i < 4; i++) cyc_u(6'd0, 6'd0, 1, 0);
    exp_u(6'd0, 6'd0);
    chk("t6_w2_maxout", mo_u, exp_mo_u);
    for (int i = 0; i < 4; i++) cyc_u(6'd0, 6'd0, 1, 0);
    exp_u(6'd0, 6'd0);
    chk("t6_w3_maxout", mo_u, exp_mo_u);
    cyc_u(6'd0, 6'd0, 1, 0);
    cyc_u(6'd25, 6'd0, 1, 0);
    cyc_u(6'd0, 6'd0, 1, 0);
    cyc_u(6'd0, 6'd0, 1, 0);
    exp_u(6'd25, 6'd0);
    chk("t6_w4_valid", mv_u, 1'b1);
    chk("t6_w4_maxout", mo_u, exp_mo_u);

    // Signed: ch0 -32,5,-7,2 / ch1 31,0,0,0
    cyc_s(6'h20, 6'd31); chk("s1_s1_valid", mv_s, 1'b0);
    cyc_s(6'd5, 6'd0);
    cyc_s(6'h39, 6'd0);
    cyc_s(6'd2, 6'd0);
    exp_s(6'd31, 6'd31);
    chk("s1_close_valid", mv_s, 1'b1);
    chk("s1_close_maxout", mo_s, exp_mo_s);
    chk("s1_close_clip", clip_s, 2'b11);
    // ch0 -7,3,-2,6 / ch1 -1,0,0,0
    cyc_s(6'h39, 6'h3F); chk("s2_s1_valid", mv_s, 1'b0);
    cyc_s(6'd3, 6'd0);
    cyc_s(6'h3E, 6'd0);
    cyc_s(6'd6, 6'd0);
    exp_s(6'd7, 6'd1);
    chk("s2_close_valid", mv_s, 1'b1);
    chk("s2_close_maxout", mo_s, exp_mo_s);
    chk("s2_close_clip", clip_s, 2'b00);
    chk("s2_uns_idle_valid", mv_u, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/peak_meter.md
Name: peak_meter

Overview:
- Multi-channel windowed peak detector for the ADC audio path.
- Tracks the per-channel maximum magnitude over a window of 2^WIN_LOG2 accepted samples.
- At window close, publishes all channel peaks together with a one-cycle valid strobe and per-channel clip flags.
- Sits between the ADC sample deserialiser and the level display / meter logic.
- Supports unsigned or two's-complement input.

Parameters:
- BUS_WIDTH, 6, bits per channel sample.
- NCH, 2, number of channels; packed buses hold channel k in bits [k*BUS_WIDTH +: BUS_WIDTH].
- WIN_LOG2, 9, window length = 2^WIN_LOG2 accepted samples (legal range 1..16).
- SIGNED, 0, 0 = samples unsigned; 1 = two's complement, magnitude is used.

Ports:
- dclk  in  1  sample-domain clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- din  in  NCH*BUS_WIDTH  packed channel samples.
- din_valid  in  1  din accepted on this edge when high.
- clear  in  1  synchronous window restart; published outputs keep their values.
- maxout  out  NCH*BUS_WIDTH  packed per-channel peak of the last completed window.
- maxout_valid  out  1  one-cycle pulse: maxout/clip just updated.
- clip  out  NCH  per-channel: full-scale magnitude seen in the last completed window.

Behaviour:
- Reset (rst high at posedge, highest priority): maxout=0, maxout_valid=0, clip=0, all running peaks=0, sample count=0, hold state (optional feature)=0.
- Magnitude, SIGNED=0: mag = sample.
- Magnitude, SIGNED=1: mag = |sample|, saturated, so the most negative code maps to 2^(BUS_WIDTH-1)-1. mag width is BUS_WIDTH; the MSB is always 0.
- Full-scale: SIGNED=0 when sample is all ones; SIGNED=1 when sample is the max positive code or the most negative code.
- Per accepted sample (din_valid=1, clear=0): run_max[k] <= max(run_max[k], mag[k]); run_clip[k] |= fullscale[k]; count <= count+1, wrapping modulo 2^WIN_LOG2.
- Window close: an accepted sample arrives while count == 2^WIN_LOG2-1. On that same edge:
  - maxout[k] <= max(run_max[k], mag[k]); clip[k] <= run_clip[k] | fullscale[k].
  - maxout_valid <= 1.
  - run_max <= 0; run_clip <= 0; count <= 0.
- Published-value latency: the value reflects the closing sample itself and is visible the cycle after the closing edge.
- maxout_valid is high for exactly one cycle per window. It is 0 on every other cycle, including cycles where din_valid=0.
- din_valid=0: no state changes except that maxout_valid drops to 0.
- clear=1 with din_valid=0: run_max=0, run_clip=0, count=0; maxout and clip unchanged; no valid pulse.
- clear=1 with din_valid=1: the window restarts and this sample is the first of the new window: count=1, run_max=mag, run_clip=fullscale. No close occurs even if count was at its last value.
- Back-to-back valid samples every cycle are supported with no stall. There is no backpressure; the consumer must take maxout on the pulse.
- Channels are fully independent except for the shared count and the shared strobe.

Optional Feature:
- Macro: PEAK_METER_HOLD_DECAY_EN.
- Defined:
  - Each channel keeps hold[k].
  - At window close: new = close peak; if new >= hold[k] then hold[k] <= new, else hold[k] <= hold[k]-1, saturating at 0.
  - maxout[k] is driven from the updated hold[k] rather than the raw close peak. This gives a ballistic meter: instant attack, 1 LSB decay per window.
  - clear does not touch hold; rst zeroes it.
- Undefined:
  - No hold registers.
  - maxout is the raw window peak as described above.

Test Plan:
- Unsigned, NCH=2, WIN_LOG2=2: ch0 stream 3,9,4,1 and ch1 stream 0,0,0,63 with din_valid every cycle -> one maxout_valid pulse after the 4th sample; maxout ch0=9, ch1=63; clip=2'b10; next window of all zeros -> maxout=0, clip=0.
- Gapped valid: same 4 samples with din_valid low 3 cycles between each -> exactly one pulse, after the 4th valid sample; maxout unchanged during the gaps.
- SIGNED=1, BUS_WIDTH=6: ch0 samples -32,5,-7,2 -> maxout ch0=31, clip[0]=1; samples -7,3,-2,6 -> maxout ch0=7, clip[0]=0.
- clear mid-window: 2 samples of 40, then clear together with sample 10, then 3 samples of 1 (WIN_LOG2=2) -> pulse after the 3rd 1; maxout=10; the earlier 40 is discarded.
- rst asserted one cycle before window close -> no pulse; maxout=0; next full window of value 5 -> pulse with maxout=5 after exactly 4 valid samples.
- PEAK_METER_HOLD_DECAY_EN defined: window peaks 20,0,0,25 -> published maxout 20,19,18,25.
